ov7670_config_seq: RTL

Reads the OV7670 register-initialisation table out of the synchronous config ROM, one entry at a time, and hands each register/value pair to the SCCB master over a valid/ready handshake. Sits between the config ROM and the SCCB master in the camera bring-up path. Handles in-table delay and end markers. Reports busy/done to the top-level camera control.

---
 rtl/ov7670_pkg.sv | 27 ++
 rtl/ov7670_config_seq_delay_timer.sv | 34 +++
 rtl/ov7670_config_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// ov7670_pkg
// Shared definitions for the OV7670 bring-up path: sequencer state encoding,
// in-table marker words, and the layout of one config-ROM entry. The ROM
// wrapper, the sequencer and the SCCB writer all import these so the marker
// values can never drift apart.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_ROM,
        ST_DECODE,
        ST_SEND,
        ST_DELAY,
        ST_DONE
    } cfg_state_t;

    // Reserved entry values; no real OV7670 register write uses these pairs.
    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] value;
    } cfg_entry_t;

endpackage

// File: rtl/ov7670_config_seq_delay_timer.sv
// cfg_delay_timer
// Loadable down-counter with a zero flag. It stops at zero rather than
// wrapping, so a stray dec after expiry is harmless.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load        load load_val (has priority over dec)
//   dec         decrement by one when non-zero
//   load_val    value to load
//   zero        count is zero
module cfg_delay_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq
// Walks the OV7670 init table in the external synchronous config ROM and
// hands each {reg, value} pair to the SCCB master over valid/ready. Handles
// the end marker (stop) and the delay marker (pause DELAY_MS milliseconds).
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start                  one-cycle pulse; honoured only in IDLE and DONE
//   rom_addr / rom_data    ROM address out, data back one cycle later
//   sccb_valid/ready       write request handshake to SCCB master
//   sccb_reg / sccb_data   register address / value of the pending write
//   busy / done            walk in progress / table completed
module ov7670_config_seq
    import ov7670_pkg::*;
#(
    parameter  int WIDTH       = 16,
    parameter  int DEPTH       = 256,
    parameter  int CLK_FREQ_HZ = 25_000_000,
    parameter  int DELAY_MS    = 10,
    localparam int ADDRW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [ADDRW-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic             sccb_valid,
    input  logic             sccb_ready,
    output logic [7:0]       sccb_reg,
    output logic [7:0]       sccb_data,
    output logic             busy,
    output logic             done
);

    localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam int CNTW         = $clog2(DELAY_CYCLES + 1);

    cfg_state_t       state, state_d;
    cfg_entry_t       entry, entry_d;
    logic [ADDRW-1:0] addr_d;
    logic             valid_d;
    logic [7:0]       reg_d, data_d;
    logic             advance;
    logic             tmr_load, tmr_dec, tmr_zero;

    // Loaded with N-1 so that the zero check in DELAY lands on the Nth cycle.
    cfg_delay_timer #(.CW(CNTW)) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (CNTW'(DELAY_CYCLES - 1)),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rom_addr   <= '0;
            entry      <= '0;
            sccb_valid <= 1'b0;
            sccb_reg   <= '0;
            sccb_data  <= '0;
        end else begin
            state      <= state_d;
            rom_addr   <= addr_d;
            entry      <= entry_d;
            sccb_valid <= valid_d;
            sccb_reg   <= reg_d;
            sccb_data  <= data_d;
        end
    end

    always_comb begin
        state_d  = state;
        addr_d   = rom_addr;
        entry_d  = entry;
        valid_d  = sccb_valid;
        reg_d    = sccb_reg;
        data_d   = sccb_data;
        advance  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            // ROM sees the held address this cycle; data is back next cycle.
            ST_FETCH:    state_d = ST_WAIT_ROM;
            ST_WAIT_ROM: begin
                entry_d = cfg_entry_t'(rom_data[15:0]);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (entry == CFG_END) begin
                    state_d = ST_DONE;
                end else if (entry == CFG_DELAY) begin
                    tmr_load = 1'b1;
                    state_d  = ST_DELAY;
                end else begin
                    valid_d = 1'b1;
                    reg_d   = entry.reg_addr;
                    data_d  = entry.value;
                    state_d = ST_SEND;
                end
            end
            // sccb_valid is always high here, so ready alone marks acceptance.
            ST_SEND: begin
                if (sccb_ready) begin
                    valid_d = 1'b0;
                    advance = 1'b1;
                end
            end
            ST_DELAY: begin
                if (tmr_zero) advance = 1'b1;
                else          tmr_dec = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Last ROM slot ends the walk instead of wrapping back to address 0.
        if (advance) begin
            if (rom_addr == ADDRW'(DEPTH - 1)) begin
                state_d = ST_DONE;
            end else begin
                addr_d  = rom_addr + ADDRW'(1);
                state_d = ST_FETCH;
            end
        end
    end

    assign busy = (state != ST_IDLE) && (state != ST_DONE);
    assign done = (state == ST_DONE);

endmodule
